linear_output_stage: RTL and testbench



---
 rtl/linear_output_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_linear_output_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/linear_output_stage.sv
// ---------------------------------------------------------------------------
// linear_output_stage
//
// Purpose:
//   Collects NUM_CHUNKS partial (acc, ai) results from the vector multiplier
//   into one output neuron, applies the weight zero-point correction and the
//   bias, requantizes with a fixed-point multiplier and right shift (round
//   half toward +inf), adds the output zero-point and saturates the result to
//   an unsigned OUT_PRECISION feature.
//
// Handshake semantics (both streams):
//   A beat transfers on a rising clk edge where valid && ready are both high.
//   The producer holds valid and its payload stable until the transfer; the
//   consumer may raise or drop ready at any time. Here out_valid/out_data/
//   out_sat stay stable from the first out_valid cycle until out_ready.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid      partial result valid
//   in_ready      stage accepts a partial result (ACCUM only, low in reset)
//   in_acc        partial dot product, signed
//   in_ai         partial feature sum, signed
//   cfg_w_zp      weight zero-point, signed
//   cfg_bias      bias, signed
//   cfg_mult      requant multiplier, unsigned
//   cfg_shift     requant right shift
//   cfg_out_zp    output zero-point, signed
//   out_valid     result valid
//   out_ready     downstream accepts result
//   out_data      quantized output feature
//   out_sat       out_data was clamped
//   dbg_state     current FSM state (ACCUM=0 .. OUTPUT=4)
// ---------------------------------------------------------------------------
module linear_output_stage #(
    parameter int NUM_CHUNKS    = 4,
    parameter int OUT_PRECISION = 8,
    parameter int MULT_WIDTH    = 16,
    parameter int SHIFT_WIDTH   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_acc,
    input  logic [31:0]              in_ai,
    input  logic [7:0]               cfg_w_zp,
    input  logic [31:0]              cfg_bias,
    input  logic [MULT_WIDTH-1:0]    cfg_mult,
    input  logic [SHIFT_WIDTH-1:0]   cfg_shift,
    input  logic [7:0]               cfg_out_zp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_PRECISION-1:0] out_data,
    output logic                     out_sat,
    output logic [2:0]               dbg_state
);

    localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0]       LAST_CNT  = CNT_W'(NUM_CHUNKS - 1);
    localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
    localparam logic [SHIFT_WIDTH-1:0] SHIFT_ONE = SHIFT_WIDTH'(1);
    // Largest representable output value, in the 66-bit rounding domain.
    localparam logic signed [65:0]     OUT_MAX   = (66'sd1 <<< OUT_PRECISION) - 66'sd1;

    typedef enum logic [2:0] {
        ST_ACCUM   = 3'd0,
        ST_CORRECT = 3'd1,
        ST_SCALE   = 3'd2,
        ST_ROUND   = 3'd3,
        ST_OUTPUT  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic signed [39:0]       r_sum_acc;
    logic signed [39:0]       r_sum_ai;
    logic [CNT_W-1:0]         r_chunk_cnt;

    // Configuration captured at the last-chunk handshake so the whole result
    // computation sees one consistent set of values.
    logic [7:0]               r_w_zp;
    logic [31:0]              r_bias;
    logic [MULT_WIDTH-1:0]    r_mult;
    logic [SHIFT_WIDTH-1:0]   r_shift;
    logic [7:0]               r_out_zp;

    logic signed [47:0]       r_corr;
    logic signed [63:0]       r_prod;
    logic [OUT_PRECISION-1:0] r_out_data;
    logic                     r_out_sat;

    logic                     w_in_fire;
    logic                     w_last_chunk;
    logic signed [39:0]       w_in_acc40;
    logic signed [39:0]       w_in_ai40;
    logic signed [47:0]       w_sum_acc48;
    logic signed [47:0]       w_sum_ai48;
    logic signed [47:0]       w_w_zp48;
    logic signed [47:0]       w_bias48;
    logic signed [47:0]       w_corr;
    logic signed [63:0]       w_corr64;
    logic signed [63:0]       w_mult64;
    logic signed [63:0]       w_prod;
    logic signed [65:0]       w_prod66;
    logic signed [65:0]       w_round66;
    logic signed [65:0]       w_shifted;
    logic signed [65:0]       w_y;
    logic [OUT_PRECISION-1:0] w_q_data;
    logic                     w_q_sat;

    assign in_ready     = (r_state == ST_ACCUM) && !rst;
    assign w_in_fire    = in_valid && in_ready;
    assign w_last_chunk = (r_chunk_cnt == LAST_CNT);

    assign out_valid = (r_state == ST_OUTPUT);
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign dbg_state = r_state;

    // Sign extensions into the accumulation / correction domains.
    assign w_in_acc40  = {{8{in_acc[31]}}, in_acc};
    assign w_in_ai40   = {{8{in_ai[31]}}, in_ai};
    assign w_sum_acc48 = {{8{r_sum_acc[39]}}, r_sum_acc};
    assign w_sum_ai48  = {{8{r_sum_ai[39]}}, r_sum_ai};
    assign w_w_zp48    = {{40{r_w_zp[7]}}, r_w_zp};
    assign w_bias48    = {{16{r_bias[31]}}, r_bias};

    // An 8x40 signed product always fits in 48 bits, so nothing is lost here.
    assign w_corr = w_sum_acc48 - (w_w_zp48 * w_sum_ai48) + w_bias48;

    // The multiplier is unsigned: zero-extend it before the signed multiply.
    assign w_corr64 = {{16{r_corr[47]}}, r_corr};
    assign w_mult64 = {{(64 - MULT_WIDTH){1'b0}}, r_mult};
    assign w_prod   = w_corr64 * w_mult64;

    // Rounding is done two bits wider than the product so the rounding
    // constant and the zero-point add cannot wrap before the clamp.
    assign w_prod66  = {{2{r_prod[63]}}, r_prod};
    assign w_round66 = (r_shift != '0) ? (66'sd1 <<< (r_shift - SHIFT_ONE)) : 66'sd0;
    assign w_shifted = (w_prod66 + w_round66) >>> r_shift;
    assign w_y       = w_shifted + {{58{r_out_zp[7]}}, r_out_zp};

    always_comb begin
        w_q_data = w_y[OUT_PRECISION-1:0];
        w_q_sat  = 1'b0;
        if (w_y < 66'sd0) begin
            w_q_data = '0;
            w_q_sat  = 1'b1;
        end else if (w_y > OUT_MAX) begin
            w_q_data = '1;
            w_q_sat  = 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ACCUM:   if (w_in_fire && w_last_chunk) w_next_state = ST_CORRECT;
            ST_CORRECT: w_next_state = ST_SCALE;
            ST_SCALE:   w_next_state = ST_ROUND;
            ST_ROUND:   w_next_state = ST_OUTPUT;
            ST_OUTPUT:  if (out_ready) w_next_state = ST_ACCUM;
            default:    w_next_state = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_sum_acc   <= '0;
            r_sum_ai    <= '0;
            r_chunk_cnt <= '0;
            r_w_zp      <= '0;
            r_bias      <= '0;
            r_mult      <= '0;
            r_shift     <= '0;
            r_out_zp    <= '0;
            r_corr      <= '0;
            r_prod      <= '0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_ACCUM: begin
                    if (w_in_fire) begin
                        // Sums wrap modulo 2^40 by construction.
                        r_sum_acc <= r_sum_acc + w_in_acc40;
                        r_sum_ai  <= r_sum_ai + w_in_ai40;
                        if (w_last_chunk) begin
                            r_chunk_cnt <= '0;
                            r_w_zp      <= cfg_w_zp;
                            r_bias      <= cfg_bias;
                            r_mult      <= cfg_mult;
                            r_shift     <= cfg_shift;
                            r_out_zp    <= cfg_out_zp;
                        end else begin
                            r_chunk_cnt <= r_chunk_cnt + CNT_ONE;
                        end
                    end
                end
                ST_CORRECT: r_corr <= w_corr;
                ST_SCALE:   r_prod <= w_prod;
                ST_ROUND: begin
                    r_out_data <= w_q_data;
                    r_out_sat  <= w_q_sat;
                end
                ST_OUTPUT: begin
                    // Sums stay live through CORRECT, so they are cleared only
                    // once the result has left the stage.
                    if (out_ready) begin
                        r_sum_acc <= '0;
                        r_sum_ai  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_linear_output_stage.sv
// ---------------------------------------------------------------------------
// tb_linear_output_stage
//
// Directed bench for linear_output_stage (NUM_CHUNKS=4, OUT_PRECISION=8).
// Expected {out_sat, out_data} values are hand-computed and pushed into
// exp_q when a neuron is issued; a separate monitor pops and compares on
// every output transfer.
// ---------------------------------------------------------------------------
module tb_linear_output_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_acc = '0;
    logic [31:0] in_ai = '0;
    logic [7:0]  cfg_w_zp = '0;
    logic [31:0] cfg_bias = '0;
    logic [15:0] cfg_mult = '0;
    logic [4:0]  cfg_shift = '0;
    logic [7:0]  cfg_out_zp = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_sat;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_hs = 0;

    logic [8:0] exp_q[$];

    linear_output_stage #(
        .NUM_CHUNKS(4),
        .OUT_PRECISION(8),
        .MULT_WIDTH(16),
        .SHIFT_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_acc(in_acc),
        .in_ai(in_ai),
        .cfg_w_zp(cfg_w_zp),
        .cfg_bias(cfg_bias),
        .cfg_mult(cfg_mult),
        .cfg_shift(cfg_shift),
        .cfg_out_zp(cfg_out_zp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_sat(out_sat),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [7:0] wzp, input logic [31:0] bias,
                           input logic [15:0] mult, input logic [4:0] shift,
                           input logic [7:0] ozp);
        cfg_w_zp   = wzp;
        cfg_bias   = bias;
        cfg_mult   = mult;
        cfg_shift  = shift;
        cfg_out_zp = ozp;
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the transfer edge.
    task automatic send_beat(input logic [31:0] acc, input logic [31:0] ai);
        int n;
        in_valid = 1'b1;
        in_acc   = acc;
        in_ai    = ai;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("beat_accept_timeout", 0, 1);
        else last_hs = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_neuron(input logic [31:0] acc_first, input logic [31:0] acc_rest,
                               input logic [31:0] ai);
        send_beat(acc_first, ai);
        for (int i = 0; i < 3; i++) send_beat(acc_rest, ai);
    endtask

    // Waits for out_valid and checks it rose exactly 4 cycles after the last chunk.
    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid) check({name, "_timeout"}, 0, 1);
        else check({name, "_latency"}, cyc - last_hs, 4);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {55'd0, out_sat, out_data}, 64'h1ff);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e[7:0]);
                check("out_sat", out_sat, e[8]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t_prev;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_state", dbg_state, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        next_cycle();

        // 400 - 2*40 + 20 = 340; 340*3 = 1020; (1020+2)>>2 = 255
        set_cfg(8'd2, 32'd20, 16'd3, 5'd2, 8'd0);
        exp_q.push_back({1'b0, 8'd255});
        send_neuron(32'd100, 32'd100, 32'd10);
        wait_out_valid("basic");
        next_cycle();

        // 340 unscaled -> clamps high
        set_cfg(8'd2, 32'd20, 16'd1, 5'd0, 8'd0);
        exp_q.push_back({1'b1, 8'd255});
        send_neuron(32'd100, 32'd100, 32'd10);
        wait_out_valid("clamp_hi");
        next_cycle();

        // corr=-7: (-7+1)>>>1 = -3; -3+10 = 7
        set_cfg(8'd2, 32'd0, 16'd1, 5'd1, 8'd10);
        exp_q.push_back({1'b0, 8'd7});
        send_neuron(-32'sd7, 32'd0, 32'd0);
        wait_out_valid("round_neg");
        next_cycle();

        // corr=-100: (-99)>>>1 = -50 -> clamps to 0
        set_cfg(8'd2, 32'd0, 16'd1, 5'd1, 8'd0);
        exp_q.push_back({1'b1, 8'd0});
        send_neuron(-32'sd100, 32'd0, 32'd0);
        wait_out_valid("clamp_lo");
        next_cycle();

        // w_zp=-3, sum_ai=20, bias=-10: 0 + 60 - 10 = 50; *2 = 100
        set_cfg(8'hfd, 32'hffff_fff6, 16'd2, 5'd0, 8'd0);
        exp_q.push_back({1'b0, 8'd100});
        send_neuron(32'd0, 32'd0, 32'd5);
        wait_out_valid("neg_wzp");
        next_cycle();

        // Backpressure: 255 + (-5) = 250, held for 5 cycles
        set_cfg(8'd2, 32'd20, 16'd3, 5'd2, 8'hfb);
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 8'd250});
        send_neuron(32'd100, 32'd100, 32'd10);
        wait_out_valid("bp");
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            in_valid = ~in_valid;
            in_acc   = 32'd1000;
            in_ai    = 32'd7;
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 250);
            check("bp_in_ready", in_ready, 0);
        end
        next_cycle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        check("bp_valid_drop", out_valid, 0);
        check("bp_in_ready_back", in_ready, 1);
        next_cycle();

        // Reset mid-accumulation discards the 100 already summed
        set_cfg(8'd0, 32'd0, 16'd1, 5'd0, 8'd0);
        send_beat(32'd50, 32'd0);
        send_beat(32'd50, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        next_cycle();
        rst = 1'b0;
        exp_q.push_back({1'b0, 8'd4});
        send_neuron(32'd1, 32'd1, 32'd0);
        wait_out_valid("midrst");
        next_cycle();

        // Config change right after the last chunk, then a back-to-back neuron
        set_cfg(8'd0, 32'd5, 16'd1, 5'd0, 8'd0);
        exp_q.push_back({1'b0, 8'd45});
        send_neuron(32'd10, 32'd10, 32'd0);
        cfg_bias = 32'd100;
        t_prev = last_hs;
        exp_q.push_back({1'b0, 8'd104});
        send_beat(32'd1, 32'd0);
        check("b2b_gap", last_hs - t_prev, 5);
        for (int i = 0; i < 3; i++) send_beat(32'd1, 32'd0);
        wait_out_valid("b2b");

        // Drain
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
